// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the bubble encoding, default reset PC and memory size, and the next-PC select codes.
package instr_fetch_unit_pkg;

  localparam int unsigned INSTR_W           = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  // Which source the PC takes next; also tells the IF/ID register what to do.
  typedef enum logic [1:0] {
    PC_SEL_FETCH    = 2'd0,
    PC_SEL_STALL    = 2'd1,
    PC_SEL_HALT     = 2'd2,
    PC_SEL_REDIRECT = 2'd3
  } pc_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection for the fetch stage: redirect > stall > halted > sequential +4.
// Also flags out-of-range PCs and redirect targets that are not word aligned.
module pc_next_sel
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_next,
  output pc_sel_e     sel,
  output logic        halted,
  output logic        target_misaligned
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  always_comb begin
    sel               = PC_SEL_FETCH;
    pc_next           = pc + 32'd4;
    halted            = (pc > LAST_PC);
    target_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

    if (redirect_valid) begin
      sel     = PC_SEL_REDIRECT;
      pc_next = word_align(redirect_target);
    end else if (stall) begin
      sel     = PC_SEL_STALL;
      pc_next = pc;
    end else if (halted) begin
      sel     = PC_SEL_HALT;
      pc_next = pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Redirects flush IF/ID, out-of-range PCs insert bubbles, and a counter tracks valid fetches.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc_plus4,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               halted,
  output logic               misaligned,
  output logic [31:0]        fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  pc_sel_e     sel;
  logic        target_misaligned;

  assign imem_addr = pc;

  pc_next_sel #(
    .MEM_BYTES (MEM_BYTES)
  ) u_pc_next_sel (
    .pc                (pc),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .pc_next           (pc_next),
    .sel               (sel),
    .halted            (halted),
    .target_misaligned (target_misaligned)
  );

  // Stall leaves IF/ID untouched; redirect and halt both leave a bubble behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_instr    <= NOP_INSTR;
      misaligned     <= 1'b0;
      fetch_count    <= 32'd0;
    end else begin
      pc <= pc_next;
      if (target_misaligned) begin
        misaligned <= 1'b1;
      end
      case (sel)
        PC_SEL_REDIRECT, PC_SEL_HALT: begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
        PC_SEL_FETCH: begin
          if_id_valid    <= 1'b1;
          if_id_pc       <= pc;
          if_id_pc_plus4 <= pc + 32'd4;
          if_id_instr    <= imem_instr;
          fetch_count    <= fetch_count + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
